ex_mem_stage: RTL and testbench

- Execute-to-memory boundary register. Captures one ALU result per beat, together with the instruction's PC, destination register, control bits and store data.
- Forwards each beat to the memory stage over a valid/ready handshake. Contains a 2-entry skid buffer, so upstream ready is a registered signal and never depends combinationally on downstream ready.
- Traps signed add/sub overflow: a trapping instruction is dropped and its PC is recorded in a sticky exception register for the coprocessor/control unit.

---
 rtl/ex_mem_stage.sv | 136 +++++++++++++
 tb/tb_ex_mem_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM boundary register with 2-entry skid buffer and overflow trap
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  input  logic          alu_negative,
  input  logic          alu_overflow,
  input  logic          ovf_trap,
  input  logic [DW-1:0] pc,
  input  logic [RW-1:0] wsel,
  input  logic          regwen,
  input  logic          dmemren,
  input  logic          dmemwen,
  input  logic [DW-1:0] store_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_zero,
  output logic          out_negative,
  output logic [DW-1:0] out_pc,
  output logic [RW-1:0] out_wsel,
  output logic          out_regwen,
  output logic          out_dmemren,
  output logic          out_dmemwen,
  output logic [DW-1:0] out_store_data,
  output logic          exc_valid,
  output logic [DW-1:0] exc_pc,
  input  logic          exc_clear
);

  localparam int PW = 3*DW + RW + 5;

  logic [PW-1:0] r_h;
  logic [PW-1:0] r_s;
  logic          r_h_valid;
  logic          r_s_valid;
  logic          r_in_ready;
  logic          r_exc_valid;
  logic [DW-1:0] r_exc_pc;

  logic [PW-1:0] w_in_pl;
  logic          w_accept;
  logic          w_trap;
  logic          w_enq;
  logic          w_pop;
  logic          w_h_valid_nxt;
  logic          w_s_valid_nxt;
  logic          w_h_load;
  logic          w_s_load;
  logic [PW-1:0] w_h_data_nxt;

  assign w_in_pl  = {alu_out, alu_zero, alu_negative, pc, wsel,
                     regwen, dmemren, dmemwen, store_data};
  // A beat offered during flush is discarded outright, trap included.
  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_trap   = w_accept & ovf_trap & alu_overflow;
  assign w_enq    = w_accept & ~w_trap;
  assign w_pop    = r_h_valid & out_ready;

  always_comb begin
    w_h_valid_nxt = r_h_valid;
    w_s_valid_nxt = r_s_valid;
    w_h_load      = 1'b0;
    w_s_load      = 1'b0;
    w_h_data_nxt  = w_in_pl;
    if (flush) begin
      w_h_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
    end else if (r_s_valid) begin
      // Full: upstream is stalled, so only a pop can change anything.
      if (w_pop) begin
        w_h_load      = 1'b1;
        w_h_data_nxt  = r_s;
        w_s_valid_nxt = 1'b0;
      end
    end else if (r_h_valid) begin
      if (w_pop && w_enq) begin
        w_h_load = 1'b1;
      end else if (w_pop) begin
        w_h_valid_nxt = 1'b0;
      end else if (w_enq) begin
        w_s_load      = 1'b1;
        w_s_valid_nxt = 1'b1;
      end
    end else if (w_enq) begin
      w_h_load      = 1'b1;
      w_h_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_h         <= '0;
      r_s         <= '0;
      r_h_valid   <= 1'b0;
      r_s_valid   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_exc_valid <= 1'b0;
      r_exc_pc    <= '0;
    end else begin
      r_h_valid  <= w_h_valid_nxt;
      r_s_valid  <= w_s_valid_nxt;
      r_in_ready <= ~w_s_valid_nxt;
      if (w_h_load) r_h <= w_h_data_nxt;
      if (w_s_load) r_s <= w_in_pl;
      // First trap wins, unless the pending one is being cleared this cycle.
      if (w_trap) begin
        r_exc_valid <= 1'b1;
        if (!r_exc_valid || exc_clear) r_exc_pc <= pc;
      end else if (exc_clear) begin
        r_exc_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_h_valid;
  assign exc_valid = r_exc_valid;
  assign exc_pc    = r_exc_pc;
  assign {out_result, out_zero, out_negative, out_pc, out_wsel,
          out_regwen, out_dmemren, out_dmemwen, out_store_data} = r_h;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Directed self-checking bench for ex_mem_stage
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          nrst, flush, in_valid, in_ready;
  logic [DW-1:0] alu_out, pc, store_data;
  logic          alu_zero, alu_negative, alu_overflow, ovf_trap;
  logic [RW-1:0] wsel;
  logic          regwen, dmemren, dmemwen;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result, out_pc, out_store_data, exc_pc;
  logic          out_zero, out_negative, out_regwen, out_dmemren, out_dmemwen;
  logic [RW-1:0] out_wsel;
  logic          exc_valid, exc_clear;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DW(DW), .RW(RW)) u_dut (
    .CLK(clk), .nRST(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .ovf_trap(ovf_trap),
    .pc(pc), .wsel(wsel), .regwen(regwen), .dmemren(dmemren),
    .dmemwen(dmemwen), .store_data(store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_negative(out_negative),
    .out_pc(out_pc), .out_wsel(out_wsel), .out_regwen(out_regwen),
    .out_dmemren(out_dmemren), .out_dmemwen(out_dmemwen),
    .out_store_data(out_store_data),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_clear(exc_clear)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] res, input logic [DW-1:0] p);
    in_valid = 1'b1;
    alu_out  = res;
    pc       = p;
  endtask

  initial begin
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_out = '0; pc = '0;
    store_data = '0; alu_zero = 1'b0; alu_negative = 1'b0;
    alu_overflow = 1'b0; ovf_trap = 1'b0; wsel = '0; regwen = 1'b0;
    dmemren = 1'b0; dmemwen = 1'b0; out_ready = 1'b0; exc_clear = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_exc_valid", exc_valid, 0);
    check_eq("rst_exc_pc", exc_pc, 0);
    check_eq("rst_out_result", out_result, 0);

    // Single beat with full payload
    out_ready = 1'b1;
    beat(32'h10, 32'h40);
    wsel = 5'd5; regwen = 1'b1; dmemwen = 1'b1; store_data = 32'hDEAD_BEEF;
    alu_zero = 1'b1; alu_negative = 1'b1;
    tick();
    in_valid = 1'b0; wsel = '0; regwen = 1'b0; dmemwen = 1'b0;
    store_data = '0; alu_zero = 1'b0; alu_negative = 1'b0;
    check_eq("single_valid", out_valid, 1);
    check_eq("single_result", out_result, 32'h10);
    check_eq("single_pc", out_pc, 32'h40);
    check_eq("single_payload",
             {out_wsel, out_regwen, out_dmemren, out_dmemwen, out_zero, out_negative},
             {5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
    check_eq("single_store", out_store_data, 32'hDEAD_BEEF);
    tick();
    check_eq("single_drained", out_valid, 0);

    // Backpressure fills the skid entry
    out_ready = 1'b0;
    beat(32'd1, 32'h50);
    tick();
    check_eq("bp_ready_after_a", in_ready, 1);
    beat(32'd2, 32'h54);
    tick();
    in_valid = 1'b0;
    check_eq("bp_ready_full", in_ready, 0);
    check_eq("bp_head", out_result, 1);
    tick();
    check_eq("bp_head_stable", out_result, 1);
    out_ready = 1'b1;
    tick();
    check_eq("bp_second", out_result, 2);
    check_eq("bp_second_valid", out_valid, 1);
    check_eq("bp_ready_back", in_ready, 1);
    tick();
    check_eq("bp_drained", out_valid, 0);

    // Full-rate streaming
    for (int i = 0; i < 8; i++) begin
      beat(i, 32'h80 + 4*i);
      tick();
      check_eq($sformatf("stream_res%0d", i), out_result, i);
      check_eq($sformatf("stream_v%0d", i), {out_valid, in_ready}, 2'b11);
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_drained", out_valid, 0);

    // Overflow traps
    ovf_trap = 1'b1; alu_overflow = 1'b1;
    beat(32'hAAAA, 32'h100);
    tick();
    check_eq("trap1_exc_valid", exc_valid, 1);
    check_eq("trap1_exc_pc", exc_pc, 32'h100);
    check_eq("trap1_no_out", out_valid, 0);
    beat(32'hBBBB, 32'h200);
    tick();
    check_eq("trap2_first_wins", exc_pc, 32'h100);
    check_eq("trap2_no_out", out_valid, 0);
    beat(32'hCCCC, 32'h300);
    exc_clear = 1'b1;
    tick();
    check_eq("trapclr_valid", exc_valid, 1);
    check_eq("trapclr_pc", exc_pc, 32'h300);
    in_valid = 1'b0;
    tick();
    exc_clear = 1'b0;
    check_eq("clear_only", exc_valid, 0);
    // Overflow ignored without ovf_trap
    ovf_trap = 1'b0;
    beat(32'h77, 32'h400);
    tick();
    in_valid = 1'b0; alu_overflow = 1'b0;
    check_eq("unsigned_enq_valid", out_valid, 1);
    check_eq("unsigned_enq_res", out_result, 32'h77);
    check_eq("unsigned_no_exc", exc_valid, 0);
    tick();
    ovf_trap = 1'b1; alu_overflow = 1'b1;
    beat(32'h0, 32'h500);
    tick();
    in_valid = 1'b0; ovf_trap = 1'b0; alu_overflow = 1'b0;
    check_eq("trap5_pc", exc_pc, 32'h500);

    // Flush at occupancy 2 with a third beat offered
    out_ready = 1'b0;
    beat(32'hA1, 32'h600);
    tick();
    beat(32'hA2, 32'h604);
    tick();
    check_eq("fl_full", in_ready, 0);
    beat(32'hA3, 32'h608);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_out_valid", out_valid, 0);
    check_eq("fl_in_ready", in_ready, 1);
    check_eq("fl_exc", {exc_valid, exc_pc}, {1'b1, 32'h500});
    out_ready = 1'b1;
    tick();
    check_eq("fl_nothing", out_valid, 0);
    // Trap beat offered with flush while ready is discarded
    ovf_trap = 1'b1; alu_overflow = 1'b1;
    beat(32'h0, 32'h700);
    exc_clear = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; exc_clear = 1'b0;
    ovf_trap = 1'b0; alu_overflow = 1'b0;
    check_eq("fl_trap_dropped", exc_valid, 0);
    check_eq("fl_trap_pc", exc_pc, 32'h500);
    check_eq("fl_trap_no_out", out_valid, 0);

    // Mid-operation reset at occupancy 2 with exception pending
    ovf_trap = 1'b1; alu_overflow = 1'b1;
    beat(32'h0, 32'h800);
    tick();
    ovf_trap = 1'b0; alu_overflow = 1'b0;
    out_ready = 1'b0;
    beat(32'hB1, 32'h900);
    tick();
    beat(32'hB2, 32'h904);
    tick();
    in_valid = 1'b0;
    check_eq("pre_rst_state", {exc_valid, in_ready, out_valid}, 3'b101);
    nrst = 1'b0; flush = 1'b1;
    tick();
    nrst = 1'b1; flush = 1'b0;
    check_eq("mrst_out_valid", out_valid, 0);
    check_eq("mrst_in_ready", in_ready, 1);
    check_eq("mrst_exc", {exc_valid, exc_pc}, 33'h0);
    check_eq("mrst_payload", {out_result, out_pc}, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
